// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot gate arbiter and the per-gate
// barrier controllers that sit underneath it.
//   entry_state_e  : entry FSM encoding (IDLE / GRANT)
//   gate_status_e  : status codes a per-gate controller reports upward
//   DEFAULT_*      : default lot sizing used by the arbiter top
package parking_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } entry_state_e;

   typedef enum logic [1:0] {
      GATE_IDLE     = 2'd0,
      GATE_ADMITTED = 2'd1,
      GATE_DENIED   = 2'd2,
      GATE_EXIT_ERR = 2'd3
   } gate_status_e;

   localparam int DEFAULT_CAPACITY    = 8;
   localparam int DEFAULT_HOLD_CYCLES = 4;

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Bundle between the gate controllers and the lot-wide arbiter.
//   master : gate side  - drives entry_req/exit_req, observes responses
//   slave  : arbiter    - observes requests, drives grant/deny/ack/status
interface parking_gate_arbiter_if #(
   parameter int NUM_GATES = 4,
   parameter int CAPACITY  = 8
);
   localparam int OCC_W = $clog2(CAPACITY + 1);

   logic [NUM_GATES-1:0] entry_req;
   logic [NUM_GATES-1:0] exit_req;
   logic [NUM_GATES-1:0] entry_grant;
   logic [NUM_GATES-1:0] entry_deny;
   logic [NUM_GATES-1:0] exit_ack;
   logic                 exit_err;
   logic [OCC_W-1:0]     occupancy;
   logic [OCC_W-1:0]     space_available;
   logic                 full;
   logic                 empty;

   modport master (
      output entry_req, exit_req,
      input  entry_grant, entry_deny, exit_ack, exit_err,
      input  occupancy, space_available, full, empty
   );

   modport slave (
      input  entry_req, exit_req,
      output entry_grant, entry_deny, exit_ack, exit_err,
      output occupancy, space_available, full, empty
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping around.
//   req     : pending request vector
//   ptr     : starting search position
//   gnt     : one-hot of the selected request
//   gnt_idx : index of the selected request
//   any     : at least one request is set
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);
   logic [IW-1:0] j;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      j       = '0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(ptr) + k) % N);
         if (!any && req[j]) begin
            any     = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = j;
         end
      end
   end
endmodule

// File: rtl/parking_gate_arbiter.sv
// Lot-wide arbiter: sole owner of the occupancy count. Picks one entry and
// one exit per cycle, round-robin within each class.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of parking_gate_arbiter_if (requests in,
//                grant/deny/ack/err pulses and occupancy status out)
//
// Entry FSM
//   state | meaning
//   IDLE  | no gate admitted; arbitrate pending entry requests
//   GRANT | entry_grant held for the admitted gate, hold counter running
module parking_gate_arbiter
   import parking_pkg::*;
#(
   parameter int NUM_GATES   = 4,
   parameter int CAPACITY    = DEFAULT_CAPACITY,
   parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
   input logic                   clk,
   input logic                   rst_n,
   parking_gate_arbiter_if.slave bus
);
   localparam int OCC_W  = $clog2(CAPACITY + 1);
   localparam int IDX_W  = $clog2(NUM_GATES);
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_GATES - 1);

   entry_state_e         state_q, state_d;
   logic [NUM_GATES-1:0] entry_prev_q, exit_prev_q;
   logic [NUM_GATES-1:0] entry_pend_q, entry_pend_d, exit_pend_q, exit_pend_d;
   logic [IDX_W-1:0]     entry_ptr_q, entry_ptr_d, exit_ptr_q, exit_ptr_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic [NUM_GATES-1:0] grant_q, grant_d, deny_q, deny_d, ack_q, ack_d;
   logic                 err_q, err_d;
   logic [OCC_W-1:0]     occ_q, occ_d, space_q, space_d;
   logic                 full_q, full_d, empty_q, empty_d;
   logic                 inc, dec;

   logic [NUM_GATES-1:0] entry_gnt, exit_gnt;
   logic [IDX_W-1:0]     entry_idx, exit_idx;
   logic                 entry_any, exit_any;

   rr_arbiter #(.N(NUM_GATES), .IW(IDX_W)) u_entry_rr (
      .req(entry_pend_q), .ptr(entry_ptr_q),
      .gnt(entry_gnt), .gnt_idx(entry_idx), .any(entry_any)
   );

   rr_arbiter #(.N(NUM_GATES), .IW(IDX_W)) u_exit_rr (
      .req(exit_pend_q), .ptr(exit_ptr_q),
      .gnt(exit_gnt), .gnt_idx(exit_idx), .any(exit_any)
   );

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      grant_d      = grant_q;
      deny_d       = '0;
      ack_d        = '0;
      err_d        = 1'b0;
      entry_pend_d = entry_pend_q;
      exit_pend_d  = exit_pend_q;
      entry_ptr_d  = entry_ptr_q;
      exit_ptr_d   = exit_ptr_q;
      inc          = 1'b0;
      dec          = 1'b0;

      if (exit_any) begin
         ack_d       = exit_gnt;
         exit_pend_d = exit_pend_d & ~exit_gnt;
         exit_ptr_d  = (exit_idx == LAST) ? '0 : exit_idx + IDX_W'(1);
         // Exit from an empty lot is flagged but never wraps the count.
         if (occ_q == '0) err_d = 1'b1;
         else             dec   = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (entry_any) begin
               entry_pend_d = entry_pend_d & ~entry_gnt;
               entry_ptr_d  = (entry_idx == LAST) ? '0 : entry_idx + IDX_W'(1);
               // Decision uses pre-exit occupancy: a full lot denies even
               // if an exit is serviced in the same cycle.
               if (occ_q < CAP_V) begin
                  inc     = 1'b1;
                  grant_d = entry_gnt;
                  hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                  state_d = GRANT;
               end else begin
                  deny_d = entry_gnt;
               end
            end
         end
         GRANT: begin
            if (hold_q == '0) begin
               grant_d = '0;
               state_d = IDLE;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // New edges are OR-ed in last so an edge on a pending gate is absorbed.
      entry_pend_d = entry_pend_d | (bus.entry_req & ~entry_prev_q);
      exit_pend_d  = exit_pend_d  | (bus.exit_req  & ~exit_prev_q);

      occ_d   = occ_q + OCC_W'(inc) - OCC_W'(dec);
      space_d = CAP_V - occ_d;
      full_d  = (occ_d == CAP_V);
      empty_d = (occ_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         entry_prev_q <= '0;
         exit_prev_q  <= '0;
         entry_pend_q <= '0;
         exit_pend_q  <= '0;
         entry_ptr_q  <= '0;
         exit_ptr_q   <= '0;
         hold_q       <= '0;
         grant_q      <= '0;
         deny_q       <= '0;
         ack_q        <= '0;
         err_q        <= 1'b0;
         occ_q        <= '0;
         space_q      <= CAP_V;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         entry_prev_q <= bus.entry_req;
         exit_prev_q  <= bus.exit_req;
         entry_pend_q <= entry_pend_d;
         exit_pend_q  <= exit_pend_d;
         entry_ptr_q  <= entry_ptr_d;
         exit_ptr_q   <= exit_ptr_d;
         hold_q       <= hold_d;
         grant_q      <= grant_d;
         deny_q       <= deny_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         occ_q        <= occ_d;
         space_q      <= space_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
      end
   end

   assign bus.entry_grant     = grant_q;
   assign bus.entry_deny      = deny_q;
   assign bus.exit_ack        = ack_q;
   assign bus.exit_err        = err_q;
   assign bus.occupancy       = occ_q;
   assign bus.space_available = space_q;
   assign bus.full            = full_q;
   assign bus.empty           = empty_q;
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed, table-driven bench for parking_gate_arbiter (4 gates, 8 spaces,
// 4-cycle grant hold). Each table row drives the request inputs, advances
// one clock, and compares every output against the row's expectation.
module tb_parking_gate_arbiter;
   localparam int CAP = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   parking_gate_arbiter_if #(.NUM_GATES(4), .CAPACITY(CAP)) bus ();

   parking_gate_arbiter #(.NUM_GATES(4), .CAPACITY(CAP), .HOLD_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] ent;
      logic [3:0] ex;
      logic [3:0] grant;
      logic [3:0] deny;
      logic [3:0] ack;
      logic       err;
      int         occ;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_status(input string tag, input int occ);
      chk({tag, " occupancy"}, 32'(bus.occupancy), 32'(occ));
      chk({tag, " space"}, 32'(bus.space_available), 32'(CAP - occ));
      chk({tag, " full"}, 32'(bus.full), 32'(occ == CAP));
      chk({tag, " empty"}, 32'(bus.empty), 32'(occ == 0));
   endtask

   function automatic void add(input logic [3:0] ent, input logic [3:0] ex,
                               input logic [3:0] grant, input logic [3:0] deny,
                               input logic [3:0] ack, input logic err, input int occ);
      vec_t v;
      v.ent = ent; v.ex = ex; v.grant = grant; v.deny = deny;
      v.ack = ack; v.err = err; v.occ = occ;
      vecs.push_back(v);
   endfunction

   // Four cycles of grant for one gate followed by the one IDLE cycle.
   function automatic void add_grant(input logic [3:0] ent, input logic [3:0] g, input int occ);
      for (int k = 0; k < 4; k++) add(ent, 4'b0, g, 4'b0, 4'b0, 1'b0, occ);
      add(ent, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, occ);
   endfunction

   initial begin
      bus.entry_req = '0;
      bus.exit_req  = '0;

      // Three simultaneous entries from pointer 0: gates 0, 1, 3 in order.
      add(4'b1011, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 0);
      add_grant(4'b1011, 4'b0001, 1);
      add_grant(4'b1011, 4'b0010, 2);
      add_grant(4'b1011, 4'b1000, 3);
      add(4'b1011, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 3);
      add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 3);
      // Single entry on gate 2, held high: one grant only.
      add(4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 3);
      add_grant(4'b0100, 4'b0100, 4);
      add(4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 4);
      add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 4);
      // Fill to capacity; pointer now at 3 so order is 3, 0, 1, 2.
      add(4'b1111, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 4);
      add_grant(4'b1111, 4'b1000, 5);
      add_grant(4'b1111, 4'b0001, 6);
      add_grant(4'b1111, 4'b0010, 7);
      add_grant(4'b1111, 4'b0100, 8);
      add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 8);
      // Full lot: entry on gate 1 is denied for one cycle.
      add(4'b0010, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 8);
      add(4'b0010, 4'b0, 4'b0, 4'b0010, 4'b0, 1'b0, 8);
      add(4'b0010, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 8);
      add(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 8);
      // Full lot, simultaneous exit 0 and entry 3: deny plus ack, net -1.
      add(4'b1000, 4'b0001, 4'b0, 4'b0, 4'b0, 1'b0, 8);
      add(4'b1000, 4'b0001, 4'b0, 4'b1000, 4'b0001, 1'b0, 7);
      add(4'b1000, 4'b0001, 4'b0, 4'b0, 4'b0, 1'b0, 7);
      add(4'b0000, 4'b0000, 4'b0, 4'b0, 4'b0, 1'b0, 7);
      // Drain: exit pointer at 1, four back-to-back acks per burst.
      add(4'b0, 4'b1111, 4'b0, 4'b0, 4'b0, 1'b0, 7);
      add(4'b0, 4'b1111, 4'b0, 4'b0, 4'b0010, 1'b0, 6);
      add(4'b0, 4'b1111, 4'b0, 4'b0, 4'b0100, 1'b0, 5);
      add(4'b0, 4'b1111, 4'b0, 4'b0, 4'b1000, 1'b0, 4);
      add(4'b0, 4'b1111, 4'b0, 4'b0, 4'b0001, 1'b0, 3);
      add(4'b0, 4'b0000, 4'b0, 4'b0, 4'b0, 1'b0, 3);
      add(4'b0, 4'b1111, 4'b0, 4'b0, 4'b0, 1'b0, 3);
      add(4'b0, 4'b1111, 4'b0, 4'b0, 4'b0010, 1'b0, 2);
      add(4'b0, 4'b1111, 4'b0, 4'b0, 4'b0100, 1'b0, 1);
      add(4'b0, 4'b1111, 4'b0, 4'b0, 4'b1000, 1'b0, 0);
      add(4'b0, 4'b1111, 4'b0, 4'b0, 4'b0001, 1'b1, 0);
      add(4'b0, 4'b0000, 4'b0, 4'b0, 4'b0, 1'b0, 0);
      // Empty lot, exit on gate 2: ack plus error, count stays 0.
      add(4'b0, 4'b0100, 4'b0, 4'b0, 4'b0, 1'b0, 0);
      add(4'b0, 4'b0100, 4'b0, 4'b0, 4'b0100, 1'b1, 0);
      add(4'b0, 4'b0000, 4'b0, 4'b0, 4'b0, 1'b0, 0);
      // Empty lot, exit and entry together: error, occupancy ends at 1.
      add(4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0, 1'b0, 0);
      add(4'b0000, 4'b0000, 4'b0001, 4'b0, 4'b0001, 1'b1, 1);
      for (int k = 0; k < 3; k++) add(4'b0, 4'b0, 4'b0001, 4'b0, 4'b0, 1'b0, 1);
      add(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1);

      // Reset state.
      #12;
      chk("reset grant", 32'(bus.entry_grant), 32'h0);
      chk("reset deny", 32'(bus.entry_deny), 32'h0);
      chk("reset ack", 32'(bus.exit_ack), 32'h0);
      chk("reset err", 32'(bus.exit_err), 32'h0);
      chk_status("reset", 0);
      rst_n = 1'b1;
      tick();
      chk("idle grant", 32'(bus.entry_grant), 32'h0);
      chk_status("idle", 0);

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         bus.entry_req = vecs[i].ent;
         bus.exit_req  = vecs[i].ex;
         tick();
         chk({tag, " grant"}, 32'(bus.entry_grant), 32'(vecs[i].grant));
         chk({tag, " deny"}, 32'(bus.entry_deny), 32'(vecs[i].deny));
         chk({tag, " ack"}, 32'(bus.exit_ack), 32'(vecs[i].ack));
         chk({tag, " err"}, 32'(bus.exit_err), 32'(vecs[i].err));
         chk_status(tag, vecs[i].occ);
      end

      // Reset in the middle of a grant drops it without waiting for a clock.
      // Entry pointer is at 1 after the last table grant.
      bus.entry_req = 4'b0010;
      tick();
      tick();
      chk("pre-rst grant", 32'(bus.entry_grant), 32'b0010);
      chk_status("pre-rst", 2);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async-rst grant", 32'(bus.entry_grant), 32'h0);
      chk_status("async-rst", 0);
      #2;
      rst_n = 1'b1;
      // Request still high at reset release counts as a fresh edge.
      tick();
      chk("post-rst pend", 32'(bus.entry_grant), 32'h0);
      tick();
      chk("post-rst grant", 32'(bus.entry_grant), 32'b0010);
      chk_status("post-rst", 1);
      bus.entry_req = '0;
      for (int k = 0; k < 4; k++) tick();
      chk("post-rst drop", 32'(bus.entry_grant), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
